// File: rtl/victim_alloc_ctrl_lv1_pkg.sv
// Shared types and constants for the L1 miss-allocation (victim selection) controller.
// Default widths for the index/way fields are provided here when the build does not define them.

`ifndef INDEX_MSB_LV1
`define INDEX_MSB_LV1 11
`endif

`ifndef INDEX_LSB_LV1
`define INDEX_LSB_LV1 6
`endif

`ifndef ASSOC_WID_LV1
`define ASSOC_WID_LV1 2
`endif

package lv1_alloc_pkg;

    localparam int NUM_WAYS_LV1 = 4;
    localparam int MESI_WID_LV1 = 2;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        WB     = 3'd2,
        ALLOC  = 3'd3,
        UPDATE = 3'd4
    } alloc_state_t;

    // Extract the coherence state of one way from the packed per-set state vector.
    function automatic mesi_t way_mesi(
        input logic [NUM_WAYS_LV1*MESI_WID_LV1-1:0] way_state,
        input int                                   way
    );
        return mesi_t'(way_state[way*MESI_WID_LV1 +: MESI_WID_LV1]);
    endfunction

endpackage

// File: rtl/victim_alloc_ctrl_lv1_inv_way_pick.sv
// Priority encoder: finds the lowest-numbered way of a set whose MESI state is Invalid.

module inv_way_pick_lv1
    import lv1_alloc_pkg::*;
#(
    parameter int ASSOC_WID = `ASSOC_WID_LV1
) (
    input  logic [NUM_WAYS_LV1*MESI_WID_LV1-1:0] way_state,
    output logic                                 found,
    output logic [ASSOC_WID-1:0]                 way
);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        found = 1'b0;
        way   = '0;
        // Walk from the top way down so the lowest invalid way is the last one written and wins.
        for (int i = NUM_WAYS_LV1 - 1; i >= 0; i--) begin
            if (way_mesi(way_state, i) == MESI_I) begin
                found = 1'b1;
                way   = ASSOC_WID'(i);
            end
        end
    end

endmodule

// File: rtl/victim_alloc_ctrl_lv1.sv
// L1 miss-allocation controller: picks a victim way, writes it back if Modified, hands it to the
// fill path and reports the access to the pseudo-LRU block. Optional counters: VICTIM_STATS_EN.

module victim_alloc_ctrl_lv1
    import lv1_alloc_pkg::*;
#(
    parameter int INDEX_MSB = `INDEX_MSB_LV1,
    parameter int INDEX_LSB = `INDEX_LSB_LV1,
    parameter int ASSOC_WID = `ASSOC_WID_LV1,
    parameter int MESI_WID  = MESI_WID_LV1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_req,
    input  logic [INDEX_MSB-INDEX_LSB:0]   miss_index,
    input  logic [NUM_WAYS_LV1*MESI_WID-1:0] way_state,
    input  logic [ASSOC_WID-1:0]           lru_replacement,
    output logic [INDEX_MSB-INDEX_LSB:0]   lru_index,
    output logic                           lru_upd_valid,
    output logic [ASSOC_WID-1:0]           lru_upd_way,
    output logic                           wb_req,
    output logic [ASSOC_WID-1:0]           wb_way,
    input  logic                           wb_ack,
    output logic                           alloc_valid,
    output logic [ASSOC_WID-1:0]           alloc_way,
    input  logic                           alloc_ready,
`ifdef VICTIM_STATS_EN
    output logic [15:0]                    evict_cnt,
    output logic [15:0]                    wb_cnt,
`endif
    output logic                           busy
);

    localparam int INDEX_W = INDEX_MSB - INDEX_LSB + 1;

    alloc_state_t          state_q, state_d;
    logic [INDEX_W-1:0]    index_q;
    logic [ASSOC_WID-1:0]  victim_q;
    mesi_t                 victim_st_q;

    logic                  inv_found;
    logic [ASSOC_WID-1:0]  inv_way;
    logic [ASSOC_WID-1:0]  sel_way;
    mesi_t                 sel_st;

    inv_way_pick_lv1 #(
        .ASSOC_WID (ASSOC_WID)
    ) u_inv_pick (
        .way_state (way_state),
        .found     (inv_found),
        .way       (inv_way)
    );

    // Invalid ways are free to take; only a fully valid set falls back to the LRU choice.
    always_comb begin
        sel_way = inv_found ? inv_way : lru_replacement;
        sel_st  = way_mesi(way_state, int'(sel_way));
    end

    // NOTE: sequential state is written with non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (miss_req)    state_d = SELECT;
            SELECT:  state_d = (sel_st == MESI_M) ? WB : ALLOC;
            WB:      if (wb_ack)      state_d = ALLOC;
            ALLOC:   if (alloc_ready) state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q     <= '0;
            victim_q    <= '0;
            victim_st_q <= MESI_I;
        end else begin
            if (state_q == IDLE && miss_req) begin
                index_q <= miss_index;
            end
            if (state_q == SELECT) begin
                victim_q    <= sel_way;
                victim_st_q <= sel_st;
            end
        end
    end

    // Way outputs are forced to zero outside their phase so idle buses never show a stale victim.
    always_comb begin
        busy          = (state_q != IDLE);
        lru_index     = index_q;
        wb_req        = 1'b0;
        wb_way        = '0;
        alloc_valid   = 1'b0;
        alloc_way     = '0;
        lru_upd_valid = 1'b0;
        lru_upd_way   = '0;
        unique case (state_q)
            WB: begin
                wb_req = (victim_st_q == MESI_M);
                wb_way = victim_q;
            end
            ALLOC: begin
                alloc_valid = 1'b1;
                alloc_way   = victim_q;
            end
            UPDATE: begin
                lru_upd_valid = 1'b1;
                lru_upd_way   = victim_q;
            end
            default: ;
        endcase
    end

`ifdef VICTIM_STATS_EN
    logic [15:0] evict_cnt_q;
    logic [15:0] wb_cnt_q;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evict_cnt_q <= '0;
            wb_cnt_q    <= '0;
        end else begin
            if (state_q == SELECT && sel_st != MESI_I && evict_cnt_q != 16'hFFFF) begin
                evict_cnt_q <= evict_cnt_q + 16'd1;
            end
            if (state_q == WB && wb_ack && wb_cnt_q != 16'hFFFF) begin
                wb_cnt_q <= wb_cnt_q + 16'd1;
            end
        end
    end

    assign evict_cnt = evict_cnt_q;
    assign wb_cnt    = wb_cnt_q;
`endif

endmodule

// File: tb/tb_victim_alloc_ctrl_lv1.sv
// Self-checking bench for victim_alloc_ctrl_lv1: directed vector table, reset/stall corner cases,
// and randomized misses checked against a transaction-level victim model.

module tb_victim_alloc_ctrl_lv1;

    localparam int INDEX_MSB = 11;
    localparam int INDEX_LSB = 6;
    localparam int IW        = INDEX_MSB - INDEX_LSB + 1;
    localparam int AW        = 2;
    localparam int MW        = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          miss_req = 1'b0;
    logic [IW-1:0] miss_index = '0;
    logic [4*MW-1:0] way_state = '0;
    logic [AW-1:0] lru_replacement = '0;
    logic [IW-1:0] lru_index;
    logic          lru_upd_valid;
    logic [AW-1:0] lru_upd_way;
    logic          wb_req;
    logic [AW-1:0] wb_way;
    logic          wb_ack = 1'b0;
    logic          alloc_valid;
    logic [AW-1:0] alloc_way;
    logic          alloc_ready = 1'b0;
    logic          busy;
`ifdef VICTIM_STATS_EN
    logic [15:0]   evict_cnt;
    logic [15:0]   wb_cnt;
`endif

    victim_alloc_ctrl_lv1 #(
        .INDEX_MSB (INDEX_MSB),
        .INDEX_LSB (INDEX_LSB),
        .ASSOC_WID (AW),
        .MESI_WID  (MW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .miss_req        (miss_req),
        .miss_index      (miss_index),
        .way_state       (way_state),
        .lru_replacement (lru_replacement),
        .lru_index       (lru_index),
        .lru_upd_valid   (lru_upd_valid),
        .lru_upd_way     (lru_upd_way),
        .wb_req          (wb_req),
        .wb_way          (wb_way),
        .wb_ack          (wb_ack),
        .alloc_valid     (alloc_valid),
        .alloc_way       (alloc_way),
        .alloc_ready     (alloc_ready),
`ifdef VICTIM_STATS_EN
        .evict_cnt       (evict_cnt),
        .wb_cnt          (wb_cnt),
`endif
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int exp_evict = 0;
    int exp_wbc   = 0;

    typedef struct {
        logic [IW-1:0]   idx;
        logic [4*MW-1:0] ws;
        logic [AW-1:0]   lru;
        int              wb_delay;
        int              rdy_delay;
        bit              spurious;
        logic [AW-1:0]   exp_way;
        bit              exp_wb;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Victim rule: the lowest Invalid way, otherwise whatever the LRU block proposes.
    function automatic int ref_victim(input logic [4*MW-1:0] ws, input logic [AW-1:0] lru);
        for (int w = 0; w < 4; w++) begin
            if (ws[2*w +: 2] == 2'b00) return w;
        end
        return int'(lru);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},          32'(busy),          32'd0);
        check({tag, " wb_req"},        32'(wb_req),        32'd0);
        check({tag, " wb_way"},        32'(wb_way),        32'd0);
        check({tag, " alloc_valid"},   32'(alloc_valid),   32'd0);
        check({tag, " alloc_way"},     32'(alloc_way),     32'd0);
        check({tag, " lru_upd_valid"}, 32'(lru_upd_valid), 32'd0);
        check({tag, " lru_upd_way"},   32'(lru_upd_way),   32'd0);
        check({tag, " lru_index"},     32'(lru_index),     32'd0);
    endtask

    // Runs one miss from the IDLE negedge to the IDLE negedge after UPDATE, checking every cycle.
    task automatic run_miss(input logic [IW-1:0] idx, input logic [4*MW-1:0] ws,
                            input logic [AW-1:0] lru, input int wbd, input int rdd,
                            input bit spurious, input logic [AW-1:0] exp_way, input bit exp_wb);
        logic [1:0] vst;
        vst = ws[2*int'(exp_way) +: 2];
        miss_req        = 1'b1;
        miss_index      = idx;
        way_state       = ws;
        lru_replacement = lru;
        @(negedge clk);
        miss_req = 1'b0;
        check("sel busy",      32'(busy),        32'd1);
        check("sel lru_index", 32'(lru_index),   32'(idx));
        check("sel wb_req",    32'(wb_req),      32'd0);
        check("sel alloc",     32'(alloc_valid), 32'd0);
        check("sel upd",       32'(lru_upd_valid), 32'd0);
        @(negedge clk);
        if (exp_wb) begin
            for (int c = 1; c <= wbd; c++) begin
                check("wb wb_req",  32'(wb_req),      32'd1);
                check("wb wb_way",  32'(wb_way),      32'(exp_way));
                check("wb alloc",   32'(alloc_valid), 32'd0);
                wb_ack = (c == wbd);
                @(negedge clk);
            end
            wb_ack = 1'b0;
        end
        for (int c = 0; c <= rdd; c++) begin
            check("alloc valid",     32'(alloc_valid),   32'd1);
            check("alloc way",       32'(alloc_way),     32'(exp_way));
            check("alloc wb_req",    32'(wb_req),        32'd0);
            check("alloc upd",       32'(lru_upd_valid), 32'd0);
            check("alloc lru_index", 32'(lru_index),     32'(idx));
            alloc_ready = (c == rdd);
            wb_ack      = (c < rdd) && spurious;
            if (spurious && c < rdd) begin
                miss_req   = 1'b1;
                miss_index = ~idx;
            end else begin
                miss_req = 1'b0;
            end
            @(negedge clk);
        end
        alloc_ready = 1'b0;
        wb_ack      = 1'b0;
        miss_req    = 1'b0;
        check("upd valid",     32'(lru_upd_valid), 32'd1);
        check("upd way",       32'(lru_upd_way),   32'(exp_way));
        check("upd alloc",     32'(alloc_valid),   32'd0);
        check("upd busy",      32'(busy),          32'd1);
        check("upd lru_index", 32'(lru_index),     32'(idx));
        @(negedge clk);
        check("idle upd",  32'(lru_upd_valid), 32'd0);
        check("idle busy", 32'(busy),          32'd0);
        if (vst != 2'b00 && exp_evict < 65535) exp_evict++;
        if (exp_wb && exp_wbc < 65535) exp_wbc++;
`ifdef VICTIM_STATS_EN
        check("evict_cnt", 32'(evict_cnt), 32'(exp_evict));
        check("wb_cnt",    32'(wb_cnt),    32'(exp_wbc));
`endif
    endtask

    task automatic run_vec(input vec_t v);
        run_miss(v.idx, v.ws, v.lru, v.wb_delay, v.rdy_delay, v.spurious, v.exp_way, v.exp_wb);
    endtask

    initial begin
        //          idx    ws     lru  wbd rdd spur way wb
        vecs[0] = '{6'd5,  8'hD2, 2'd3, 1, 0, 1'b0, 2'd1, 1'b0}; // {M,S,I,E}: invalid way 1 first
        vecs[1] = '{6'd9,  8'h66, 2'd2, 1, 1, 1'b0, 2'd2, 1'b0}; // {S,E,S,E}: LRU way, clean
        vecs[2] = '{6'd17, 8'hFF, 2'd3, 4, 0, 1'b0, 2'd3, 1'b1}; // all M, ack after 4 cycles
        vecs[3] = '{6'd33, 8'hAA, 2'd0, 1, 6, 1'b1, 2'd0, 1'b0}; // fill stall, ignored miss_req
        vecs[4] = '{6'd63, 8'h00, 2'd2, 1, 0, 1'b0, 2'd0, 1'b0}; // all I picks way 0
        vecs[5] = '{6'd40, 8'h3F, 2'd1, 1, 0, 1'b0, 2'd3, 1'b0}; // {I,M,M,M}: way 3 invalid
        vecs[6] = '{6'd2,  8'hFF, 2'd0, 1, 2, 1'b0, 2'd0, 1'b1}; // M victim, ack in first WB cycle

        #2;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset busy", 32'(busy), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Asynchronous reset while waiting for a writeback ack.
        miss_req = 1'b1; miss_index = 6'd21; way_state = 8'hFF; lru_replacement = 2'd1;
        @(negedge clk);
        miss_req = 1'b0;
        @(negedge clk);
        check("pre-rst wb_req", 32'(wb_req), 32'd1);
        check("pre-rst wb_way", 32'(wb_way), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async rst");
        exp_evict = 0;
        exp_wbc   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after rst");

        // Two M evictions and one invalid fill starting from cleared counters.
        run_vec(vecs[2]);
        run_vec(vecs[6]);
        run_vec(vecs[4]);
`ifdef VICTIM_STATS_EN
        check("stats evict=2", 32'(evict_cnt), 32'd2);
        check("stats wb=2",    32'(wb_cnt),    32'd2);
        force dut.evict_cnt_q = 16'hFFFE;
        #1 release dut.evict_cnt_q;
        exp_evict = 65534;
        for (int k = 0; k < 3; k++) run_miss(6'd7, 8'hAA, 2'(k), 1, 0, 1'b0, 2'(k), 1'b0);
        check("evict saturated", 32'(evict_cnt), 32'hFFFF);
`endif

        for (int t = 0; t < 40; t++) begin
            logic [4*MW-1:0] ws;
            logic [AW-1:0]   lru;
            int              vw;
            bit              no_inv;
            no_inv = 1'($urandom_range(0, 1));
            for (int w = 0; w < 4; w++) begin
                int s;
                s = no_inv ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
                ws[2*w +: 2] = 2'(s);
            end
            lru = AW'($urandom_range(0, 3));
            vw  = ref_victim(ws, lru);
            run_miss(IW'($urandom), ws, lru, int'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), AW'(vw), ws[2*vw +: 2] == 2'b11);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
